vram_arbiter: RTL and testbench

- Shares one single-port 64K x 3-bit frame-buffer RAM between two requesters:
  - the VGA display path, which fetches pixels for the 256x256 image window;
  - a CPU/loader write port.
- Sits between the VGA timing counters and the RAM.
- Produces the pixel word that feeds the VGA controller's iVGA_RGB input, already aligned to the window at H 242..497, V 142..397.
- Display fetches always win; CPU writes are buffered and drained in free cycles.

---
 rtl/vram_arb_pkg.sv | 24 ++
 rtl/vram_write_fifo.sv | 91 +++++++++
 rtl/vram_arbiter.sv | 108 ++++++++++
 tb/tb_vram_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_arb_pkg.sv
// ============================================================================
// Module   : vram_arb_pkg
// Purpose  : Grant encodings and window/FIFO constants for the VRAM arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package vram_arb_pkg;

   typedef enum logic [1:0] {
      GNT_IDLE  = 2'b00,
      GNT_FETCH = 2'b01,
      GNT_WRITE = 2'b10
   } grant_e;

   localparam int c_h_fetch_start = 240;
   localparam int c_v_start       = 142;
   localparam int c_img_w         = 256;
   localparam int c_img_h         = 256;
   localparam int c_fifo_depth    = 4;

endpackage

`default_nettype wire

// File: rtl/vram_write_fifo.sv
// ============================================================================
// Module   : vram_write_fifo
// Purpose  : CPU write buffer; single entry by default, 4-deep FIFO when
//            VRAM_ARB_WRITE_FIFO_EN is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

module vram_write_fifo
   import vram_arb_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 3
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              push,
   input  logic [ADDR_W-1:0] push_addr,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W-1:0] head_addr,
   output logic [DATA_W-1:0] head_data
);

`ifdef VRAM_ARB_WRITE_FIFO_EN
   logic [ADDR_W-1:0] r_addr_mem [c_fifo_depth];
   logic [DATA_W-1:0] r_data_mem [c_fifo_depth];
   logic [1:0]        r_wr_ptr;
   logic [1:0]        r_rd_ptr;
   logic [2:0]        r_count;
   logic              w_push;
   logic              w_pop;

   assign full      = (r_count == 3'(c_fifo_depth));
   assign empty     = (r_count == 3'd0);
   assign w_push    = push && !full;
   assign w_pop     = pop && !empty;
   assign head_addr = r_addr_mem[r_rd_ptr];
   assign head_data = r_data_mem[r_rd_ptr];

   // Simultaneous push and pop leave the occupancy unchanged.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_wr_ptr <= 2'd0;
         r_rd_ptr <= 2'd0;
         r_count  <= 3'd0;
      end else begin
         if (w_push) begin
            r_addr_mem[r_wr_ptr] <= push_addr;
            r_data_mem[r_wr_ptr] <= push_data;
            r_wr_ptr             <= r_wr_ptr + 2'd1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 2'd1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 3'd1;
            2'b01:   r_count <= r_count - 3'd1;
            default: r_count <= r_count;
         endcase
      end
   end
`else
   logic              r_valid;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_data;

   assign full      = r_valid;
   assign empty     = !r_valid;
   assign head_addr = r_addr;
   assign head_data = r_data;

   // A full entry refuses new data even in the cycle it drains.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_valid <= 1'b0;
      end else if (push && !r_valid) begin
         r_valid <= 1'b1;
         r_addr  <= push_addr;
         r_data  <= push_data;
      end else if (pop) begin
         r_valid <= 1'b0;
      end
   end
`endif

endmodule

`default_nettype wire

// File: rtl/vram_arbiter.sv
// ============================================================================
// Module   : vram_arbiter
// Purpose  : Shares the frame-buffer RAM between display fetch and CPU writes;
//            VRAM_ARB_WRITE_FIFO_EN selects the 4-deep write buffer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module vram_arbiter
   import vram_arb_pkg::*;
#(
   parameter int ADDR_W        = 16,
   parameter int DATA_W        = 3,
   parameter int H_FETCH_START = c_h_fetch_start,
   parameter int V_START       = c_v_start,
   parameter int IMG_W         = c_img_w,
   parameter int IMG_H         = c_img_h
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic [9:0]        iHcounter,
   input  logic [9:0]        iVcounter,
   input  logic              iCpuReq,
   input  logic [ADDR_W-1:0] iCpuAddr,
   input  logic [DATA_W-1:0] iCpuData,
   output logic              oCpuReady,
   output logic [ADDR_W-1:0] oMemAddr,
   output logic              oMemWe,
   output logic [DATA_W-1:0] oMemWData,
   input  logic [DATA_W-1:0] iMemRData,
   output logic [DATA_W-1:0] oPixelRGB,
   output logic [1:0]        oGrant
);

   localparam logic [9:0] c_h_lo = 10'(H_FETCH_START);
   localparam logic [9:0] c_h_hi = 10'(H_FETCH_START + IMG_W);
   localparam logic [9:0] c_v_lo = 10'(V_START);
   localparam logic [9:0] c_v_hi = 10'(V_START + IMG_H);
   localparam int         c_half = ADDR_W / 2;

   grant_e            w_grant;
   logic              w_fetch_win;
   logic [9:0]        w_row;
   logic [9:0]        w_col;
   logic              w_push;
   logic              w_pop;
   logic              w_full;
   logic              w_empty;
   logic [ADDR_W-1:0] w_head_addr;
   logic [DATA_W-1:0] w_head_data;
   logic              r_fetch_d1;

   assign w_fetch_win = (iVcounter >= c_v_lo) && (iVcounter < c_v_hi) &&
                        (iHcounter >= c_h_lo) && (iHcounter < c_h_hi);
   assign w_row       = iVcounter - c_v_lo;
   assign w_col       = iHcounter - c_h_lo;
   assign w_push      = iCpuReq && !w_full;
   assign oCpuReady   = !w_full;
   assign oGrant      = w_grant;

   vram_write_fifo #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_write_fifo (
      .Clock     (Clock),
      .Reset     (Reset),
      .push      (w_push),
      .push_addr (iCpuAddr),
      .push_data (iCpuData),
      .pop       (w_pop),
      .full      (w_full),
      .empty     (w_empty),
      .head_addr (w_head_addr),
      .head_data (w_head_data)
   );

   // Display fetch always wins; a pending write is withheld during reset so it is discarded.
   always_comb begin
      w_grant   = GNT_IDLE;
      oMemAddr  = '0;
      oMemWe    = 1'b0;
      oMemWData = '0;
      w_pop     = 1'b0;
      if (w_fetch_win) begin
         w_grant  = GNT_FETCH;
         oMemAddr = {w_row[c_half-1:0], w_col[c_half-1:0]};
      end else if (!w_empty && !Reset) begin
         w_grant   = GNT_WRITE;
         oMemAddr  = w_head_addr;
         oMemWe    = 1'b1;
         oMemWData = w_head_data;
         w_pop     = 1'b1;
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_fetch_d1 <= 1'b0;
         oPixelRGB  <= '0;
      end else begin
         r_fetch_d1 <= (w_grant == GNT_FETCH);
         oPixelRGB  <= r_fetch_d1 ? iMemRData : '0;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_vram_arbiter.sv
// ============================================================================
// Module   : tb_vram_arbiter
// Purpose  : Self-checking bench for vram_arbiter with a behavioural RAM and
//            reference model; honours VRAM_ARB_WRITE_FIFO_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_vram_arbiter;

`ifdef VRAM_ARB_WRITE_FIFO_EN
   localparam int DEPTH    = 4;
   localparam int FIFTH_H  = 497;
`else
   localparam int DEPTH    = 1;
   localparam int FIFTH_H  = 503;
`endif

   typedef struct packed {
      logic [15:0] addr;
      logic [2:0]  data;
   } wreq_t;

   logic        Clock = 1'b0;
   logic        Reset;
   logic [9:0]  iHcounter;
   logic [9:0]  iVcounter;
   logic        iCpuReq;
   logic [15:0] iCpuAddr;
   logic [2:0]  iCpuData;
   logic        oCpuReady;
   logic [15:0] oMemAddr;
   logic        oMemWe;
   logic [2:0]  oMemWData;
   logic [2:0]  iMemRData;
   logic [2:0]  oPixelRGB;
   logic [1:0]  oGrant;

   int n_checks = 0;
   int n_pass   = 0;

   vram_arbiter dut (
      .Clock     (Clock),
      .Reset     (Reset),
      .iHcounter (iHcounter),
      .iVcounter (iVcounter),
      .iCpuReq   (iCpuReq),
      .iCpuAddr  (iCpuAddr),
      .iCpuData  (iCpuData),
      .oCpuReady (oCpuReady),
      .oMemAddr  (oMemAddr),
      .oMemWe    (oMemWe),
      .oMemWData (oMemWData),
      .iMemRData (iMemRData),
      .oPixelRGB (oPixelRGB),
      .oGrant    (oGrant)
   );

   always #5 Clock = ~Clock;

   // RAM: unwritten locations hold addr[2:0]; read data one cycle after the address.
   bit [2:0] ram_w  [65536];
   bit       ram_wr [65536];
   always @(posedge Clock) begin
      if (oMemWe) begin
         ram_w[oMemAddr]  <= oMemWData;
         ram_wr[oMemAddr] <= 1'b1;
      end
      iMemRData <= ram_wr[oMemAddr] ? ram_w[oMemAddr] : oMemAddr[2:0];
   end

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // Reference model: pending-write queue, model memory, pixel delay queue.
   bit [2:0] m_mem [65536];
   bit       m_wr  [65536];
   wreq_t    wq[$];
   int       pix_q[$];
   int       m_pix;
   bit       model_on = 1'b0;

   always @(negedge Clock) begin
      int  v, h, fa, eg, ea, ewe, ewd, erdy;
      bit  win;
      wreq_t nr;
      v   = int'(iVcounter);
      h   = int'(iHcounter);
      win = (v >= 142) && (v < 398) && (h >= 240) && (h < 496);
      fa  = (((v - 142) & 255) << 8) | ((h - 240) & 255);
      if (win)                          eg = 1;
      else if (!Reset && wq.size() > 0) eg = 2;
      else                              eg = 0;
      ea   = (eg == 1) ? fa : (eg == 2) ? int'(wq[0].addr) : 0;
      ewe  = (eg == 2) ? 1 : 0;
      ewd  = (eg == 2) ? int'(wq[0].data) : 0;
      erdy = (wq.size() < DEPTH) ? 1 : 0;
      if (model_on) begin
         check("grant", int'(oGrant), eg);
         check("mem_addr", int'(oMemAddr), ea);
         check("mem_we", int'(oMemWe), ewe);
         check("mem_wdata", int'(oMemWData), ewd);
         check("cpu_ready", int'(oCpuReady), erdy);
         check("pixel", int'(oPixelRGB), m_pix);
      end
      if (Reset) begin
         model_on = 1'b1;
         wq.delete();
         pix_q.delete();
         pix_q.push_back(0);
         m_pix = 0;
      end else if (model_on) begin
         m_pix = pix_q.pop_front();
         pix_q.push_back(win ? (m_wr[fa] ? int'(m_mem[fa]) : (fa & 7)) : 0);
         if (eg == 2) begin
            m_mem[wq[0].addr] = wq[0].data;
            m_wr[wq[0].addr]  = 1'b1;
            wq.delete(0);
         end
         if (iCpuReq && erdy == 1) begin
            nr.addr = iCpuAddr;
            nr.data = iCpuData;
            wq.push_back(nr);
         end
      end
   end

   // Requester: holds the head request until the DUT accepts it.
   wreq_t rq[$];
   int    obs_grant, obs_addr, obs_we, obs_wd, obs_rdy, obs_pix;
   bit    obs_acc;

   task automatic run(input int h, input int v);
      iHcounter = 10'(h);
      iVcounter = 10'(v);
      if (rq.size() > 0) begin
         iCpuReq  = 1'b1;
         iCpuAddr = rq[0].addr;
         iCpuData = rq[0].data;
      end else begin
         iCpuReq  = 1'b0;
         iCpuAddr = '0;
         iCpuData = '0;
      end
      @(negedge Clock);
      obs_grant = int'(oGrant);
      obs_addr  = int'(oMemAddr);
      obs_we    = int'(oMemWe);
      obs_wd    = int'(oMemWData);
      obs_rdy   = int'(oCpuReady);
      obs_pix   = int'(oPixelRGB);
      obs_acc   = iCpuReq && oCpuReady && !Reset;
      if (obs_acc) rq.delete(0);
      @(posedge Clock);
      #1;
   endtask

   function automatic wreq_t mk(input int a, input int d);
      wreq_t r;
      r.addr = 16'(a);
      r.data = 3'(d);
      return r;
   endfunction

   initial begin
      int stall_we, acc_cnt, fifth_h, n_acc, we_cnt;
      int wlog[$];
      Reset     = 1'b1;
      iHcounter = '0;
      iVcounter = '0;
      iCpuReq   = 1'b0;
      iCpuAddr  = '0;
      iCpuData  = '0;
      #1;
      for (int i = 0; i < 3; i++) run(0, 0);
      Reset = 1'b0;
      run(1, 0);
      check("rst_grant", obs_grant, 0);
      check("rst_ready", obs_rdy, 1);
      check("rst_pixel", obs_pix, 0);
      check("rst_we", obs_we, 0);

      // Read alignment on the first image row.
      for (int h = 0; h < 800; h++) begin
         run(h, 142);
         if (h == 241) check("align_241", obs_pix, 0);
         if (h == 242) check("align_242", obs_pix, 0);
         if (h == 243) check("align_243", obs_pix, 1);
         if (h == 244) check("align_244", obs_pix, 2);
         if (h == 497) check("align_497", obs_pix, 7);
         if (h == 498) check("align_498", obs_pix, 0);
      end

      // Write outside the window.
      for (int h = 0; h < 20; h++) begin
         if (h == 5) rq.push_back(mk('h1234, 5));
         run(h, 10);
         if (h == 6) begin
            check("out_ready", obs_rdy, (DEPTH == 1) ? 0 : 1);
            check("out_we", obs_we, 1);
            check("out_addr", obs_addr, 'h1234);
            check("out_wdata", obs_wd, 5);
         end
         if (h == 7) begin
            check("out_ready_back", obs_rdy, 1);
            check("out_we_after", obs_we, 0);
         end
      end

      // Write arriving mid-fetch stalls until the window closes.
      stall_we = 0;
      for (int h = 0; h < 800; h++) begin
         if (h == 300) rq.push_back(mk('h0001, 3));
         run(h, 200);
         if (h > 300 && h <= 495 && obs_we != 0) stall_we++;
         if (h == 495) check("stall_we", stall_we, 0);
         if (h == 496) begin
            check("stall_issue_we", obs_we, 1);
            check("stall_issue_addr", obs_addr, 1);
            check("stall_issue_grant", obs_grant, 2);
            check("stall_issue_wdata", obs_wd, 3);
         end
      end

      // Burst of five requests during fetch.
      acc_cnt = 0;
      fifth_h = -1;
      n_acc   = 0;
      wlog.delete();
      for (int h = 0; h < 800; h++) begin
         if (h == 250)
            for (int i = 0; i < 5; i++) rq.push_back(mk('h0100 + i, i + 1));
         run(h, 150);
         if (obs_acc) begin
            n_acc++;
            if (h < 496) acc_cnt++;
            if (n_acc == 5) fifth_h = h;
         end
         if (obs_we != 0) wlog.push_back(obs_addr);
         if (h == 300) check("burst_ready_full", obs_rdy, 0);
         if (h == 495) check("burst_accepted", acc_cnt, DEPTH);
      end
      check("burst_fifth_h", fifth_h, FIFTH_H);
      check("burst_writes", wlog.size(), 5);
      for (int i = 0; i < 5; i++)
         check("burst_order", (i < wlog.size()) ? wlog[i] : -1, 'h0100 + i);

      // Reset mid-line with a write pending.
      we_cnt = 0;
      for (int h = 0; h < 800; h++) begin
         if (h == 290) rq.push_back(mk('h0abc, 6));
         Reset = (h == 300);
         run(h, 160);
         if (h > 300 && obs_we != 0) we_cnt++;
         if (h == 301) begin
            check("mrst_pixel", obs_pix, 0);
            check("mrst_grant", obs_grant, 1);
            check("mrst_ready", obs_rdy, 1);
         end
         if (h == 303) check("mrst_resume_pix", obs_pix, 5);
      end
      Reset = 1'b0;
      check("mrst_no_write", we_cnt, 0);

      // Randomized lines, including window edges and counter wrap.
      for (int l = 0; l < 24; l++) begin
         int v;
         case (l)
            0:       v = 141;
            1:       v = 397;
            2:       v = 398;
            3:       v = 520;
            default: v = (l % 2 == 0) ? int'($urandom_range(142, 397)) : int'($urandom_range(0, 520));
         endcase
         for (int h = 0; h < 800; h++) begin
            if (rq.size() == 0 && $urandom_range(0, 7) == 0) begin
               int n;
               n = int'($urandom_range(1, 3));
               for (int k = 0; k < n; k++)
                  rq.push_back(mk(int'($urandom_range(0, 65535)), int'($urandom_range(0, 7))));
            end
            run(h, v);
         end
      end
      for (int h = 0; h < 40; h++) run(h, 0);
      check("requests_drained", rq.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
